mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
Main control unit for the multicycle MIPS datapath, directly upstream of the ALU control decoder. A Moore FSM decodes the instruction opcode and sequences the fetch, decode, execute, memory and write-back steps. Each cycle it drives the datapath enables, the mux selects and the 2-bit aluOp that the ALU control decoder consumes. Memory wait states are handled through a mem_ready handshake.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch on equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instr[31:26] from the instruction register
mem_ready  input  1  memory has completed the current access
PCWrite  output  1  unconditional PC write enable
PCWriteCond  output  1  PC write enable qualified by ALU zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemtoReg  output  1  write-back data select: 1 = MDR
IRWrite  output  1  instruction register load
PCSource  output  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
aluOp  output  2  to ALU control decoder: 00 = add, 01 = sub, 10 = use func
ALUSrcB  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = reg A
RegWrite  output  1  register file write enable
RegDst  output  1  destination register select: 1 = rd, 0 = rt
illegal_op  output  1  unrecognised opcode, one-cycle pulse
state  output  4  current state, for debug

Behaviour:
- One clock domain. Reset is synchronous and active-high: while reset is high at a rising edge of clock, the state becomes FETCH.
- While reset is high, all outputs are forced to 0, including aluOp = 00 and state = 0. After reset is released, outputs are a pure function of the registered state and of mem_ready. No registered outputs.
- State encoding is 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, ALUSrcB=01, aluOp=00.
  - IRWrite=mem_ready, PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11, aluOp=00.
  - R-type -> EXEC.
  - lw or sw -> MEMADR.
  - beq -> BEQ.
  - j -> JUMP.
  - addi -> ADDIEX.
  - Any other opcode -> FETCH, with illegal_op=1 for this DECODE cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, aluOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay while mem_ready=0; go to FETCH when mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, aluOp=10. Go to RCOMP.
- RCOMP: RegWrite=1, RegDst=1. Go to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, aluOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, aluOp=00. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Go to FETCH.
- Latency in cycles, with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- opcode is sampled only in DECODE and MEMADR. It must stay stable from the cycle after FETCH completes until the instruction returns to FETCH.
- Unused state codes 12-15 go to FETCH on the next edge, with all outputs 0.
- aluOp=11 is never driven.
- Reset asserted in the middle of an instruction, including during a memory wait: outputs drop to 0 in the same cycle and the state is FETCH after the edge. No partial write occurs after reset is sampled.
- Memory write strobes (MemWrite, RegWrite, PCWrite, IRWrite) are never asserted in a cycle where reset=1.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encoding constants;
  - the opcode constants;
  - the aluOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10);
  - the PCSource and ALUSrcB encodings.
  The ALU control decoder imports the same aluOp constants from this package.
- No sub-module. The block is a state register plus next-state logic plus output decode, in one module.

Test Plan:
- Reset: hold reset=1 for 3 cycles, with mem_ready=1 and opcode=OP_LW.
  -> All outputs are 0. After release, state=0 with MemRead=1, ALUSrcB=01, aluOp=00.
- lw with mem_ready=1.
  -> State sequence 0,1,2,3,4,0. MEMWB drives RegWrite=1 and MemtoReg=1. Exactly 5 cycles.
- sw with mem_ready=0 for 2 cycles in MEMWR.
  -> State sequence 0,1,2,5,5,5,0. MemWrite=1 and IorD=1 during all three MEMWR cycles.
- R-type, then beq, then j, then addi, back to back with mem_ready=1.
  -> aluOp is 10 in EXEC, 01 in BEQ and 00 in ADDIEX.
  -> PCSource=10 with PCWrite=1 in JUMP.
  -> RegDst=1 in RCOMP; RegDst=0 in ADDIWB.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH.
  -> IRWrite=0 and PCWrite=0 until the cycle where mem_ready=1, then both are 1 for exactly one cycle.
- Illegal opcode 6'b111111.
  -> illegal_op=1 for exactly the DECODE cycle, then FETCH. No RegWrite or MemWrite is asserted.
  -> Additionally, assert reset during MEMRD: the state is 0 after the edge and no RegWrite occurs.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// and the select/aluOp codes consumed by the datapath and ALU control decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    // Picks the state that follows DECODE; unknown opcodes fall back to FETCH.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:     decode_target = S_EXEC;
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_BEQ:       decode_target = S_BEQ;
            OP_J:         decode_target = S_JUMP;
            OP_ADDI:      decode_target = S_ADDIEX;
            default:      decode_target = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode from the
// registered state (plus mem_ready for the memory handshake) and are held at 0 during reset.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] aluOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = reset ? 4'd0 : state_q;

    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        aluOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REGB;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;

        // Reset suppresses every strobe in the same cycle, so no partial write escapes.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    aluOp   = ALUOP_ADD;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    state_d = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB    = SRCB_IMM_SHL;
                    aluOp      = ALUOP_ADD;
                    state_d    = decode_target(opcode);
                    illegal_op = (decode_target(opcode) == S_FETCH);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    aluOp   = ALUOP_ADD;
                    if (opcode == OP_LW) begin
                        state_d = S_MEMRD;
                    end else if (opcode == OP_SW) begin
                        state_d = S_MEMWR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    RegDst   = 1'b0;
                    state_d  = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REGB;
                    aluOp   = ALUOP_FUNC;
                    state_d = S_RCOMP;
                end
                S_RCOMP: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REGB;
                    aluOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                    state_d  = S_FETCH;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    aluOp   = ALUOP_ADD;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b0;
                    state_d  = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule
